// File: rtl/shift_and_sub_divider_if.sv
// shift_and_sub_divider_if: start/done request and result bundle shared by the divider and its controller
interface shift_and_sub_divider_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;
    logic             done;
    modport master (output start, dividend, divisor, input quotient, remainder, div_by_zero, busy, done);
    modport slave  (input start, dividend, divisor, output quotient, remainder, div_by_zero, busy, done);
endinterface

// File: rtl/shift_and_sub_divider.sv
// shift_and_sub_divider: restoring unsigned divider, one quotient bit per clock, start/done handshake
module shift_and_sub_divider #(parameter int WIDTH = 8) (
    input logic                  clk,
    input logic                  reset,
    shift_and_sub_divider_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, INIT, BUSY, FINISH} state_t;
    state_t           state;
    logic [WIDTH-1:0] dvd_q, dvs_q, quot_acc, rem_acc;
    logic [WIDTH:0]   trial;
    logic [CW-1:0]    count;
    logic             dvz;
    // A restore always leaves a value below the divisor, so the top remainder bit is never needed.
    assign trial    = {rem_acc, quot_acc[WIDTH-1]} - {1'b0, dvs_q};
    assign dvz      = dvs_q == '0;
    assign bus.busy = state != IDLE;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            dvd_q           <= '0;
            dvs_q           <= '0;
            quot_acc        <= '0;
            rem_acc         <= '0;
            count           <= '0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    dvd_q <= bus.dividend;
                    dvs_q <= bus.divisor;
                    state <= INIT;
                end
                INIT: begin
                    rem_acc  <= '0;
                    quot_acc <= dvd_q;
                    count    <= '0;
                    state    <= dvz ? FINISH : BUSY;
                end
                BUSY: begin
                    rem_acc  <= trial[WIDTH] ? {rem_acc[WIDTH-2:0], quot_acc[WIDTH-1]} : trial[WIDTH-1:0];
                    quot_acc <= {quot_acc[WIDTH-2:0], ~trial[WIDTH]};
                    count    <= count + CW'(1);
                    if (count == LAST) state <= FINISH;
                end
                FINISH: begin
                    bus.quotient    <= dvz ? '1 : quot_acc;
                    bus.remainder   <= dvz ? dvd_q : rem_acc;
                    bus.div_by_zero <= dvz;
                    bus.done        <= 1'b1;
                    state           <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_and_sub_divider.sv
// tb_shift_and_sub_divider: directed and random checks of the divider at WIDTH 8 and 16 against plain / and %
module tb_shift_and_sub_divider;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    shift_and_sub_divider_if #(.WIDTH(8))  i8();
    shift_and_sub_divider_if #(.WIDTH(16)) i16();
    shift_and_sub_divider #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(i8));
    shift_and_sub_divider #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(i16));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        i8.start = 1'b1; i8.dividend = a; i8.divisor = b;
        @(posedge clk); #1;
        i8.start = 1'b0;
        i8.dividend = 8'($urandom_range(0, 255));
        i8.divisor  = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        while (i8.done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        int lat;
        issue8(a, b);
        wait_done8(lat);
        check("lat8", lat, (b == 0) ? 2 : 10);
        check("quo8", i8.quotient, (b == 0) ? 32'd255 : 32'(a / b));
        check("rem8", i8.remainder, (b == 0) ? 32'(a) : 32'(a % b));
        check("dbz8", i8.div_by_zero, 32'(b == 0));
        @(posedge clk); #1;
        check("done8_drop", i8.done, 0);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b);
        int lat = 0;
        @(negedge clk);
        i16.start = 1'b1; i16.dividend = a; i16.divisor = b;
        @(posedge clk); #1;
        i16.start = 1'b0; i16.dividend = 16'($urandom); i16.divisor = 16'($urandom);
        while (i16.done !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
        check("lat16", lat, (b == 0) ? 2 : 18);
        check("quo16", i16.quotient, (b == 0) ? 32'hFFFF : 32'(a / b));
        check("rem16", i16.remainder, (b == 0) ? 32'(a) : 32'(a % b));
        check("dbz16", i16.div_by_zero, 32'(b == 0));
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin @(posedge clk); #1; if (i8.done) n++; end
    endtask

    initial begin
        int lat, n;
        logic [7:0] corner [6] = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd254, 8'd255};
        i8.start = 1'b0;  i8.dividend = '0;  i8.divisor = '0;
        i16.start = 1'b0; i16.dividend = '0; i16.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_quo", i8.quotient, 0);
        check("rst_rem", i8.remainder, 0);
        check("rst_dbz", i8.div_by_zero, 0);
        check("rst_busy", i8.busy, 0);
        check("rst_done", i8.done, 0);
        @(negedge clk); reset = 1'b1;
        op8(100, 7);
        op8(255, 1); op8(5, 9); op8(0, 3); op8(255, 255); op8(128, 2);
        op8(200, 0); op8(9, 4);
        // second request lands mid-BUSY and must be dropped
        issue8(100, 7);
        repeat (4) @(posedge clk);
        @(negedge clk); i8.start = 1'b1; i8.dividend = 50; i8.divisor = 5;
        @(negedge clk); i8.start = 1'b0;
        wait_done8(lat);
        check("ign_lat", lat, 5);
        check("ign_quo", i8.quotient, 14);
        check("ign_rem", i8.remainder, 2);
        count_dones(20, n);
        check("ign_extra_done", n, 0);
        // start held during the done cycle is accepted back-to-back
        issue8(100, 7);
        wait_done8(lat);
        check("b2b_quo1", i8.quotient, 14);
        i8.start = 1'b1; i8.dividend = 50; i8.divisor = 5;
        @(posedge clk); #1;
        i8.start = 1'b0;
        wait_done8(lat);
        check("b2b_lat", lat, 10);
        check("b2b_quo2", i8.quotient, 10);
        check("b2b_rem2", i8.remainder, 0);
        // asynchronous abort in the 5th BUSY cycle
        issue8(100, 7);
        repeat (5) @(posedge clk);
        #1; reset = 1'b0; #1;
        check("abort_quo", i8.quotient, 0);
        check("abort_rem", i8.remainder, 0);
        check("abort_dbz", i8.div_by_zero, 0);
        check("abort_busy", i8.busy, 0);
        check("abort_done", i8.done, 0);
        @(negedge clk); reset = 1'b1;
        count_dones(20, n);
        check("abort_no_done", n, 0);
        op8(77, 8);
        foreach (corner[i]) begin
            op8(corner[i], 0);
            foreach (corner[j]) op8(corner[i], corner[j]);
        end
        repeat (2000) op8(8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255)));
        op16(16'hFFFF, 16'd1); op16(16'd1000, 16'd0); op16(16'd3, 16'hFFFF);
        repeat (500) op16(16'($urandom), ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 65535) >> $urandom_range(0, 15)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
